// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Load/store adapter between the core data-access stage and one
//             port of a byte-write block RAM. Handles byte/half/word accesses,
//             splits word-crossing accesses into two beats, absorbs the RAM
//             read latency and sign/zero-extends returned load data.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [31:0]           req_addr_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_split_o,
  output logic                  mem_en_o,
  output logic                  mem_regce_o,
  output logic                  mem_rst_o,
  output logic [3:0]            mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_din_o,
  input  logic [31:0]           mem_dout_i
);

  // Only latencies 1 and 2 are meaningful; anything else behaves as 2.
  localparam int c_LAT = (READ_LATENCY == 1) ? 1 : 2;
  localparam logic [ADDR_WIDTH-1:0] c_WORD_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BEAT0 = 3'd1,
    S_BEAT1 = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;

  // Request fields latched at handshake
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [ADDR_WIDTH-1:0] r_word;
  logic [1:0]            r_off;
  logic                  r_split;
  logic [3:0]            r_we_hi;
  logic [31:0]           r_din_hi;

  // Registered outputs (forced to zero while rst_i is high)
  logic                  r_resp_valid;
  logic [31:0]           r_resp_rdata;
  logic                  r_resp_split;
  logic                  r_mem_en;
  logic [3:0]            r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_din;

  // Read-return capture
  logic [c_LAT-1:0]      r_lo_pipe;
  logic [c_LAT-1:0]      r_hi_pipe;
  logic [31:0]           r_lo;
  logic [31:0]           r_hi;

  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_req_word;
  logic [1:0]            w_req_off;
  logic [3:0]            w_req_mask;
  logic                  w_req_split;
  logic [7:0]            w_req_we_wide;
  logic [63:0]           w_req_din_wide;
  logic                  w_issue_lo;
  logic                  w_issue_hi;
  logic                  w_cap_lo;
  logic                  w_cap_hi;
  logic [31:0]           w_lo_data;
  logic [31:0]           w_hi_data;
  logic [63:0]           w_merged_wide;
  logic [31:0]           w_merged;
  logic [31:0]           w_result;
  logic                  w_last_capture;
  logic                  w_unused;

  // ---------------------------------------------------------------------------
  // Request decode: word/offset, byte mask and lane-shifted write data.
  // The 64-bit shifts give both beats at once: low half is beat 0, high half
  // is what spills into the next word for beat 1.
  // ---------------------------------------------------------------------------
  assign w_accept       = req_valid_i && req_ready_o;
  assign w_req_word     = req_addr_i[ADDR_WIDTH+1:2];
  assign w_req_off      = req_addr_i[1:0];
  assign w_req_split    = ((req_size_i == 2'b01) && (w_req_off == 2'b11)) ||
                          (req_size_i[1] && (w_req_off != 2'b00));
  assign w_req_we_wide  = {4'b0000, w_req_mask} << w_req_off;
  assign w_req_din_wide = {32'h0000_0000, req_wdata_i} << {w_req_off, 3'b000};

  // Byte-enable mask for the requested access size (size 11 acts as word)
  always_comb begin
    w_req_mask = 4'b1111;
    case (req_size_i)
      2'b00:   w_req_mask = 4'b0001;
      2'b01:   w_req_mask = 4'b0011;
      default: w_req_mask = 4'b1111;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Latency tracking: one token per load beat travels READ_LATENCY stages,
  // and arrives in the cycle the RAM presents that beat's data.
  // ---------------------------------------------------------------------------
  assign w_issue_lo = (r_state == S_BEAT0) && !r_we;
  assign w_issue_hi = (r_state == S_BEAT1) && !r_we;
  assign w_cap_lo   = r_lo_pipe[c_LAT-1];
  assign w_cap_hi   = r_hi_pipe[c_LAT-1];

  generate
    if (c_LAT == 1) begin : g_pipe_l1
      // Single-stage token delay for low-latency RAM
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_lo_pipe <= '0;
          r_hi_pipe <= '0;
        end else begin
          r_lo_pipe <= w_issue_lo;
          r_hi_pipe <= w_issue_hi;
        end
      end
    end else begin : g_pipe_l2
      // Two-stage token delay for output-registered RAM
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_lo_pipe <= '0;
          r_hi_pipe <= '0;
        end else begin
          r_lo_pipe <= {r_lo_pipe[0], w_issue_lo};
          r_hi_pipe <= {r_hi_pipe[0], w_issue_hi};
        end
      end
    end
  endgenerate

  // Capture returning RAM data into the low/high beat holding registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lo <= 32'h0;
      r_hi <= 32'h0;
    end else begin
      if (w_cap_lo) r_lo <= mem_dout_i;
      if (w_cap_hi) r_hi <= mem_dout_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Load data path. Data arriving this cycle is bypassed so the response can
  // be registered on the same edge as the final capture.
  // ---------------------------------------------------------------------------
  assign w_lo_data      = w_cap_lo ? mem_dout_i : r_lo;
  assign w_hi_data      = w_cap_hi ? mem_dout_i : r_hi;
  assign w_merged_wide  = {w_hi_data, w_lo_data} >> {r_off, 3'b000};
  assign w_merged       = w_merged_wide[31:0];
  assign w_last_capture = r_split ? w_cap_hi : w_cap_lo;

  // Size-dependent sign/zero extension of the merged load data
  always_comb begin
    w_result = w_merged;
    case (r_size)
      2'b00:   w_result = r_uns ? {24'h0, w_merged[7:0]}
                                : {{24{w_merged[7]}}, w_merged[7:0]};
      2'b01:   w_result = r_uns ? {16'h0, w_merged[15:0]}
                                : {{16{w_merged[15]}}, w_merged[15:0]};
      default: w_result = w_merged;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Main sequencer: latches the request, drives RAM beats and the response.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_uns        <= 1'b0;
      r_word       <= '0;
      r_off        <= 2'b00;
      r_split      <= 1'b0;
      r_we_hi      <= 4'b0000;
      r_din_hi     <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_split <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 4'b0000;
      r_mem_addr   <= '0;
      r_mem_din    <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we       <= req_we_i;
            r_size     <= req_size_i;
            r_uns      <= req_unsigned_i;
            r_word     <= w_req_word;
            r_off      <= w_req_off;
            r_split    <= w_req_split;
            r_we_hi    <= w_req_we_wide[7:4];
            r_din_hi   <= w_req_din_wide[63:32];
            r_mem_en   <= 1'b1;
            r_mem_addr <= w_req_word;
            r_mem_we   <= req_we_i ? w_req_we_wide[3:0] : 4'b0000;
            r_mem_din  <= req_we_i ? w_req_din_wide[31:0] : 32'h0;
            r_state    <= S_BEAT0;
          end
        end

        S_BEAT0: begin
          if (r_split) begin
            r_mem_en   <= 1'b1;
            r_mem_addr <= r_word + c_WORD_ONE;
            r_mem_we   <= r_we ? r_we_hi : 4'b0000;
            r_mem_din  <= r_we ? r_din_hi : 32'h0;
            r_state    <= S_BEAT1;
          end else begin
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_we   <= 4'b0000;
            r_mem_din  <= 32'h0;
            if (r_we) begin
              r_resp_valid <= 1'b1;
              r_resp_rdata <= 32'h0;
              r_resp_split <= 1'b0;
              r_state      <= S_DONE;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end

        S_BEAT1: begin
          r_mem_en   <= 1'b0;
          r_mem_addr <= '0;
          r_mem_we   <= 4'b0000;
          r_mem_din  <= 32'h0;
          if (r_we) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= 32'h0;
            r_resp_split <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (w_last_capture) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_result;
            r_resp_split <= r_split;
            r_state      <= S_DONE;
          end
        end

        S_DONE: begin
          r_resp_valid <= 1'b0;
          r_resp_rdata <= 32'h0;
          r_resp_split <= 1'b0;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs: registered values, held at zero while reset is asserted so an
  // interrupted beat cannot write the RAM.
  assign req_ready_o  = (r_state == S_IDLE) && !rst_i;
  assign resp_valid_o = r_resp_valid && !rst_i;
  assign resp_rdata_o = rst_i ? 32'h0 : r_resp_rdata;
  assign resp_split_o = r_resp_split && !rst_i;
  assign mem_en_o     = r_mem_en && !rst_i;
  assign mem_we_o     = rst_i ? 4'b0000 : r_mem_we;
  assign mem_addr_o   = rst_i ? '0 : r_mem_addr;
  assign mem_din_o    = rst_i ? 32'h0 : r_mem_din;
  assign mem_regce_o  = !rst_i;
  assign mem_rst_o    = rst_i;

  // Address bits above the RAM and the spilled merge bits are intentionally dropped
  assign w_unused = ^{req_addr_i[31:ADDR_WIDTH+2], w_merged_wide[63:32]};

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side load/store adapter between the core's data-access stage and one port of the dual-port byte-write block RAM. Converts byte-addressed RV32 loads and stores (byte, half, word; signed or unsigned) into word-addressed RAM beats with byte write enables. Absorbs the RAM's fixed read latency. Splits accesses that cross a word boundary into two beats, merging or sign-extending the returned data.

## Interface
- ADDR_WIDTH, 10, RAM word-address width (RAM depth = 2**ADDR_WIDTH words)
- READ_LATENCY, 2, RAM read latency in cycles; legal values 1 (low-latency RAM) or 2 (output-registered RAM)
- clk_i  in  1  single clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid && ready
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  32  byte address; bits [ADDR_WIDTH+1:2] select the word, higher bits ignored
- req_size_i  in  2  00 byte, 01 half, 10 word; 11 treated as word
- req_unsigned_i  in  1  zero-extend load data (LBU/LHU)
- req_wdata_i  in  32  store data, right-justified
- resp_valid_o  out  1  one-cycle completion pulse (loads and stores)
- resp_rdata_o  out  32  extended load data; 0 for stores
- resp_split_o  out  1  completed access used two beats
- mem_en_o  out  1  RAM port enable
- mem_regce_o  out  1  RAM output-register enable
- mem_rst_o  out  1  RAM output reset; equals rst_i
- mem_we_o  out  4  RAM byte write enables
- mem_addr_o  out  ADDR_WIDTH  RAM word address
- mem_din_o  out  32  RAM write data, lane-aligned
- mem_dout_i  in  32  RAM read data

## Operation
- States: IDLE, BEAT0, BEAT1, WAIT, DONE. req_ready_o=1 only in IDLE and not in reset.
- Handshake in IDLE: latch we, size, unsigned, wdata, word address W, offset o=addr[1:0]. Go to BEAT0.
- Split condition: half with o=3, or word with o≠0. Bytes never split.
- BEAT0: mem_en_o=1, mem_addr_o=W.
  - Store: mem_we_o = size mask << o, truncated to 4 bits. mem_din_o = wdata << 8*o.
  - Load: mem_we_o = 0.
  - Next state is BEAT1 if split; otherwise DONE for a store, WAIT for a load.
- BEAT1: mem_addr_o = W+1 mod 2**ADDR_WIDTH (wraps to 0).
  - Store: mem_we_o = size mask >> (4-o). mem_din_o = wdata >> 8*(4-o).
  - Next: DONE for a store, WAIT for a load.
- WAIT: a latency counter captures mem_dout_i exactly READ_LATENCY cycles after each beat's issue cycle, into lo (beat0) and hi (beat1). Go to DONE after the last capture.
- Load data path:
  - merged = ({hi,lo} >> 8*o)[31:0]; hi is don't-care when not split.
  - Byte: bits [7:0], sign-extended from bit 7 unless unsigned.
  - Half: bits [15:0], sign-extended from bit 15 unless unsigned.
  - Word: all 32 bits.
- DONE: resp_valid_o=1, resp_rdata_o=result (0 for stores), resp_split_o=split. Next state is IDLE.
- mem_regce_o=1 in every non-reset cycle. mem_en_o=0 and mem_we_o=0 outside BEAT0/BEAT1.
- Reset mid-operation: return to IDLE. The in-flight request is abandoned and gets no response. A beat already written stays in RAM.

## Timing
- Reset values: req_ready_o=0 while rst_i=1; all other outputs 0. mem_rst_o=1 while in reset. req_ready_o=1 in the first cycle after reset deasserts.
- Handshake at cycle T.
  - BEAT0 issue at T+1; BEAT1 issue (if split) at T+2.
  - Aligned store: resp_valid_o at T+2. Split store: T+3.
  - Aligned load: resp_valid_o at T+2+READ_LATENCY (T+4 for latency 2). Split load: T+3+READ_LATENCY.
- req_ready_o reasserts the cycle after DONE. Minimum request spacing is therefore 3 cycles for an aligned store.
- Signals in the DONE cycle are registered outputs, held for exactly one cycle. There is no response backpressure.
- Same-port read-after-write: the write completes before the next request is accepted, so a following load always sees the new data.

## Test plan
- Reset: preload RAM word 0 = 0x8899AABB. Assert rst_i for 2 cycles during BEAT0 of a store to addr 0 with wdata 0x11223344 -> no resp_valid_o; all outputs 0 during reset; req_ready_o=1 the cycle after release.
- Aligned LW: RAM word 5 = 0xDEADBEEF, load addr 0x14 -> mem_addr_o=5 at T+1; resp_rdata_o=0xDEADBEEF with resp_valid_o at T+4 (READ_LATENCY=2) and T+3 (READ_LATENCY=1).
- Sub-word loads, word 2 = 0x80FF7F01:
  - LB 0x0A -> 0xFFFFFFFF; LBU 0x0A -> 0x000000FF.
  - LH 0x0A -> 0xFFFF80FF; LHU 0x08 -> 0x00007F01.
- Sub-word stores: SB 0x0D data 0xAB -> mem_we_o=0010, mem_din_o[15:8]=0xAB; SH 0x0E data 0x1234 -> we=1100; word 3 ends 0x1234AB00 from 0.
- Split: SW addr 0x0B data 0xA1B2C3D4 with words 2/3 = 0 -> beats we=1000 then 0111. Word 2 = 0xD4000000, word 3 = 0x00A1B2C3. LW 0x0B returns 0xA1B2C3D4, resp_split_o=1, resp at T+5.
- Wrap: LH at the top byte address of the RAM (0xFFF when ADDR_WIDTH=10), word 1023 = 0x7F000000, word 0 = 0x00000080 -> second beat mem_addr_o=0; resp_rdata_o=0xFFFF807F.
